// File: rtl/rob.sv
// In-order reorder buffer: allocates at dispatch, marks entries done from the
// completion broadcast, and retires up to R_WIDTH oldest done entries per cycle.
package rob_pkg;
    localparam int PHY_REG_W = 6;
    localparam int ROB_IDX_W = 5;

    typedef logic [PHY_REG_W-1:0] phy_reg_idx_t;

    typedef struct packed {
        logic         valid;
        phy_reg_idx_t index;
    } cdb_tag_t;

    typedef struct packed {
        cdb_tag_t               tag;
        logic [ROB_IDX_W-1:0]   rob_index;
    } complete_packet_t;
endpackage

module rob
    import rob_pkg::*;
#(
    parameter int SIZE    = 32,
    parameter int D_WIDTH = 3,
    parameter int C_WIDTH = 3,
    parameter int R_WIDTH = 3,
    parameter int IDX_W   = $clog2(SIZE)
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [D_WIDTH-1:0]                dispatch_valid,
    input  logic [D_WIDTH-1:0][4:0]           dispatch_arch,
    input  phy_reg_idx_t [D_WIDTH-1:0]        dispatch_dest,
    input  phy_reg_idx_t [D_WIDTH-1:0]        dispatch_old,
    output logic [D_WIDTH-1:0][IDX_W-1:0]     dispatch_rob_index,
    output logic [$clog2(SIZE+1)-1:0]         free_slots,
    input  complete_packet_t [C_WIDTH-1:0]    complete,
    input  logic                              flush,
    output logic [R_WIDTH-1:0]                retire_valid,
    output logic [R_WIDTH-1:0][4:0]           retire_arch,
    output phy_reg_idx_t [R_WIDTH-1:0]        retire_dest,
    output phy_reg_idx_t [R_WIDTH-1:0]        retire_old
);

    localparam int CNT_W = $clog2(SIZE+1);
    localparam int DC_W  = $clog2(D_WIDTH+1);
    localparam int RC_W  = $clog2(R_WIDTH+1);

    logic [IDX_W-1:0]  head_q, tail_q, head_d, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SIZE-1:0]   valid_q, done_q, valid_d, done_d;
    logic [4:0]        arch_q [SIZE];
    phy_reg_idx_t      dest_q [SIZE];
    phy_reg_idx_t      old_q  [SIZE];

    logic [D_WIDTH-1:0] accept;
    logic [DC_W-1:0]    accept_cnt;
    logic [R_WIDTH-1:0] retire;
    logic [RC_W-1:0]    retire_cnt;

    // The physical tag on the broadcast is irrelevant here; only rob_index matters.
    logic unused_tag_bits;
    always_comb begin
        unused_tag_bits = 1'b0;
        for (int j = 0; j < C_WIDTH; j++) begin
            unused_tag_bits = unused_tag_bits ^ (^complete[j].tag.index);
        end
    end

    assign free_slots = CNT_W'(SIZE) - count_q;

    // Dispatch handshake: dispatch_valid[i] is a request, there is no per-lane
    // ready. A lane is taken at posedge only if lanes 0..i are all requesting,
    // i < free_slots and flush is low; anything else is silently dropped, so the
    // producer compares free_slots before presenting lanes it cannot lose.
    always_comb begin : dispatch_accept
        logic run;
        run        = !flush;
        accept     = '0;
        accept_cnt = '0;
        for (int i = 0; i < D_WIDTH; i++) begin
            dispatch_rob_index[i] = tail_q + IDX_W'(i);
            if (run && dispatch_valid[i] && (CNT_W'(i) < free_slots)) begin
                accept[i]  = 1'b1;
                accept_cnt = accept_cnt + DC_W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    // Retirement looks only at registered state and never skips an undone entry.
    always_comb begin : retire_select
        logic             run;
        logic [IDX_W-1:0] idx;
        run         = 1'b1;
        idx         = '0;
        retire      = '0;
        retire_cnt  = '0;
        retire_arch = '0;
        retire_dest = '0;
        retire_old  = '0;
        for (int k = 0; k < R_WIDTH; k++) begin
            idx = head_q + IDX_W'(k);
            if (run && valid_q[idx] && done_q[idx]) begin
                retire[k]      = 1'b1;
                retire_cnt     = retire_cnt + RC_W'(1);
                retire_arch[k] = arch_q[idx];
                retire_dest[k] = dest_q[idx];
                retire_old[k]  = old_q[idx];
            end else begin
                run = 1'b0;
            end
        end
    end

    assign retire_valid = retire;

    always_comb begin : next_state
        logic [IDX_W-1:0] idx;
        idx     = '0;
        valid_d = valid_q;
        done_d  = done_q;
        // Completions check the pre-edge valid bit, so stale tags are dropped.
        for (int j = 0; j < C_WIDTH; j++) begin
            idx = IDX_W'(complete[j].rob_index);
            if (complete[j].tag.valid && valid_q[idx]) begin
                done_d[idx] = 1'b1;
            end
        end
        for (int k = 0; k < R_WIDTH; k++) begin
            idx = head_q + IDX_W'(k);
            if (retire[k]) begin
                valid_d[idx] = 1'b0;
                done_d[idx]  = 1'b0;
            end
        end
        for (int i = 0; i < D_WIDTH; i++) begin
            idx = tail_q + IDX_W'(i);
            if (accept[i]) begin
                valid_d[idx] = 1'b1;
                done_d[idx]  = 1'b0;
            end
        end
        head_d  = head_q + IDX_W'(retire_cnt);
        tail_d  = tail_q + IDX_W'(accept_cnt);
        count_d = count_q + CNT_W'(accept_cnt) - CNT_W'(retire_cnt);
        if (flush) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Payload needs no reset: it is only observed through a set valid bit.
    always_ff @(posedge clock) begin
        for (int i = 0; i < D_WIDTH; i++) begin
            if (accept[i]) begin
                arch_q[tail_q + IDX_W'(i)] <= dispatch_arch[i];
                dest_q[tail_q + IDX_W'(i)] <= dispatch_dest[i];
                old_q[tail_q + IDX_W'(i)]  <= dispatch_old[i];
            end
        end
    end

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: a reference model of occupancy/done state plus an
// in-order queue of expected retire payloads, with directed and random phases.
module tb_rob;
    import rob_pkg::*;

    localparam int SIZE = 32;
    localparam int DW   = 3;
    localparam int CW   = 3;
    localparam int RW   = 3;
    localparam int IW   = 5;

    logic                       clock = 1'b0;
    logic                       reset = 1'b0;
    logic [DW-1:0]              dispatch_valid;
    logic [DW-1:0][4:0]         dispatch_arch;
    phy_reg_idx_t [DW-1:0]      dispatch_dest;
    phy_reg_idx_t [DW-1:0]      dispatch_old;
    logic [DW-1:0][IW-1:0]      dispatch_rob_index;
    logic [5:0]                 free_slots;
    complete_packet_t [CW-1:0]  complete;
    logic                       flush;
    logic [RW-1:0]              retire_valid;
    logic [RW-1:0][4:0]         retire_arch;
    phy_reg_idx_t [RW-1:0]      retire_dest;
    phy_reg_idx_t [RW-1:0]      retire_old;

    rob #(.SIZE(SIZE), .D_WIDTH(DW), .C_WIDTH(CW), .R_WIDTH(RW)) dut (
        .clock              (clock),
        .reset              (reset),
        .dispatch_valid     (dispatch_valid),
        .dispatch_arch      (dispatch_arch),
        .dispatch_dest      (dispatch_dest),
        .dispatch_old       (dispatch_old),
        .dispatch_rob_index (dispatch_rob_index),
        .free_slots         (free_slots),
        .complete           (complete),
        .flush              (flush),
        .retire_valid       (retire_valid),
        .retire_arch        (retire_arch),
        .retire_dest        (retire_dest),
        .retire_old         (retire_old)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [16:0] exp_q[$];
    bit          m_valid [SIZE];
    bit          m_done  [SIZE];
    int          m_head, m_tail, m_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SIZE; i++) begin
            m_valid[i] = 1'b0;
            m_done[i]  = 1'b0;
        end
        m_head  = 0;
        m_tail  = 0;
        m_count = 0;
        exp_q.delete();
    endtask

    task automatic drive_idle();
        dispatch_valid = '0;
        dispatch_arch  = '0;
        dispatch_dest  = '0;
        dispatch_old   = '0;
        complete       = '0;
        flush          = 1'b0;
    endtask

    task automatic set_disp(input int lane, input int arch, input int dest, input int old);
        dispatch_valid[lane] = 1'b1;
        dispatch_arch[lane]  = 5'(arch);
        dispatch_dest[lane]  = phy_reg_idx_t'(dest);
        dispatch_old[lane]   = phy_reg_idx_t'(old);
    endtask

    task automatic disp_rand(input int lane);
        set_disp(lane, $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
    endtask

    task automatic set_comp(input int lane, input int idx);
        complete[lane].tag.valid = 1'b1;
        complete[lane].tag.index = phy_reg_idx_t'($urandom_range(0, 63));
        complete[lane].rob_index = 5'(idx % SIZE);
    endtask

    // Checks outputs for the current cycle against the model, then advances
    // the model and the DUT by one clock. Returns at the following negedge.
    task automatic cycle();
        logic [RW-1:0] exp_rv;
        logic [16:0]   exp_e;
        bit            run;
        int            idx, acc, ret_n;
        #1;
        exp_rv = '0;
        run    = 1'b1;
        ret_n  = 0;
        for (int k = 0; k < RW; k++) begin
            idx = (m_head + k) % SIZE;
            if (run && m_valid[idx] && m_done[idx]) begin
                exp_rv[k] = 1'b1;
                ret_n++;
            end else begin
                run = 1'b0;
            end
        end
        check("retire_valid", 32'(retire_valid), 32'(exp_rv));
        for (int k = 0; k < RW; k++) begin
            if (exp_rv[k]) begin
                exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                check("retire_payload", 32'({retire_arch[k], retire_dest[k], retire_old[k]}), 32'(exp_e));
            end else begin
                check("retire_idle_zero", 32'({retire_arch[k], retire_dest[k], retire_old[k]}), 0);
            end
        end
        check("free_slots", 32'(free_slots), SIZE - m_count);
        for (int i = 0; i < DW; i++) begin
            check("dispatch_rob_index", 32'(dispatch_rob_index[i]), (m_tail + i) % SIZE);
        end
        acc = 0;
        if (!flush) begin
            for (int i = 0; i < DW; i++) begin
                if (dispatch_valid[i] && acc == i && acc < SIZE - m_count) acc++;
            end
        end
        if (flush) begin
            model_reset();
        end else begin
            for (int j = 0; j < CW; j++) begin
                idx = int'(complete[j].rob_index);
                if (complete[j].tag.valid && m_valid[idx]) m_done[idx] = 1'b1;
            end
            for (int k = 0; k < ret_n; k++) begin
                idx = (m_head + k) % SIZE;
                m_valid[idx] = 1'b0;
                m_done[idx]  = 1'b0;
            end
            for (int i = 0; i < acc; i++) begin
                idx = (m_tail + i) % SIZE;
                m_valid[idx] = 1'b1;
                m_done[idx]  = 1'b0;
                exp_q.push_back({dispatch_arch[i], dispatch_dest[i], dispatch_old[i]});
            end
            m_head  = (m_head + ret_n) % SIZE;
            m_tail  = (m_tail + acc) % SIZE;
            m_count = m_count + acc - ret_n;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 100 && m_count > 0; n++) begin
            drive_idle();
            for (int j = 0; j < CW; j++) set_comp(j, m_head + j);
            cycle();
        end
        drive_idle();
        check(tag, 32'(free_slots), SIZE);
    endtask

    initial begin
        logic [14:0] idx_base;
        int          c;
        idx_base = {5'd2, 5'd1, 5'd0};

        // Clock/reset
        drive_idle();
        model_reset();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        check("reset_free", 32'(free_slots), 32);
        check("reset_rv", 32'(retire_valid), 0);
        check("reset_rob_index", 32'(dispatch_rob_index), 32'(idx_base));

        // Basic flow
        drive_idle();
        set_disp(0, 1, 10, 20);
        set_disp(1, 2, 11, 21);
        set_disp(2, 3, 12, 22);
        cycle();
        check("basic_free", 32'(free_slots), 29);
        drive_idle();
        set_comp(0, 0); set_comp(1, 1); set_comp(2, 2);
        cycle();
        check("basic_rv", 32'(retire_valid), 32'h7);
        check("basic_dest", 32'(retire_dest), 32'({6'd12, 6'd11, 6'd10}));
        check("basic_old", 32'(retire_old), 32'({6'd22, 6'd21, 6'd20}));
        drive_idle();
        cycle();
        check("basic_free_after", 32'(free_slots), 32);

        // Out-of-order completion
        drive_idle();
        for (int i = 0; i < DW; i++) disp_rand(i);
        cycle();
        drive_idle();
        set_comp(0, 4); set_comp(1, 5);
        cycle();
        check("ooo_rv_none", 32'(retire_valid), 0);
        drive_idle();
        set_comp(0, 3);
        cycle();
        check("ooo_rv_all", 32'(retire_valid), 32'h7);
        drive_idle();
        cycle();

        // Non-contiguous request
        drive_idle();
        disp_rand(0);
        disp_rand(2);
        cycle();
        check("noncontig_free", 32'(free_slots), 31);
        drive_idle();
        flush = 1'b1;
        cycle();
        check("flush_home_index", 32'(dispatch_rob_index[0]), 0);

        // Fill to full, with partial acceptance on the last request
        for (int n = 0; n < 11; n++) begin
            drive_idle();
            for (int i = 0; i < DW; i++) disp_rand(i);
            cycle();
        end
        check("partial_free", 32'(free_slots), 0);
        check("full_rob_index", 32'(dispatch_rob_index), 32'(idx_base));
        drive_idle();
        for (int i = 0; i < DW; i++) disp_rand(i);
        cycle();
        check("full_ignored_free", 32'(free_slots), 0);
        check("full_tail_held", 32'(dispatch_rob_index[0]), 0);
        drive_idle();
        set_comp(0, 0); set_comp(1, 1); set_comp(2, 2);
        cycle();
        drive_idle();
        for (int i = 0; i < DW; i++) disp_rand(i);
        check("full_retire_rv", 32'(retire_valid), 32'h7);
        cycle();
        check("retire_no_same_cycle_disp", 32'(free_slots), 3);
        drive_idle();
        for (int i = 0; i < DW; i++) disp_rand(i);
        check("wrap_rob_index", 32'(dispatch_rob_index), 32'(idx_base));
        cycle();
        check("wrap_full_again", 32'(free_slots), 0);
        c = 3;
        for (int n = 0; n < 11; n++) begin
            drive_idle();
            for (int j = 0; j < CW; j++) set_comp(j, c + j);
            c += 3;
            cycle();
        end
        drain("wrap_drain_free");

        // Flush with two done entries at the head
        drive_idle();
        flush = 1'b1;
        cycle();
        drive_idle();
        for (int i = 0; i < DW; i++) disp_rand(i);
        cycle();
        drive_idle();
        disp_rand(0); disp_rand(1);
        cycle();
        drive_idle();
        set_comp(0, 0); set_comp(1, 1);
        cycle();
        drive_idle();
        flush = 1'b1;
        disp_rand(0);
        set_comp(0, 2);
        check("flush_rv", 32'(retire_valid), 32'h3);
        cycle();
        check("flush_free", 32'(free_slots), 32);
        check("flush_rv_after", 32'(retire_valid), 0);
        drive_idle();
        set_comp(0, 3);
        cycle();
        check("late_comp_rv", 32'(retire_valid), 0);
        check("late_comp_free", 32'(free_slots), 32);

        // Asynchronous reset mid-operation
        drive_idle();
        for (int i = 0; i < DW; i++) disp_rand(i);
        cycle();
        drive_idle();
        set_comp(0, 0);
        cycle();
        check("async_pre_rv", 32'(retire_valid), 32'h1);
        drive_idle();
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("async_free", 32'(free_slots), 32);
        check("async_rv", 32'(retire_valid), 0);
        check("async_rob_index", 32'(dispatch_rob_index), 32'(idx_base));
        model_reset();
        @(negedge clock);
        reset = 1'b1;

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            drive_idle();
            for (int i = 0; i < DW; i++) begin
                if ($urandom_range(0, 3) != 0) disp_rand(i);
            end
            for (int j = 0; j < CW; j++) begin
                if ($urandom_range(0, 1) != 0) set_comp(j, m_head + $urandom_range(0, 7));
            end
            flush = ($urandom_range(0, 49) == 0);
            cycle();
        end
        drain("random_drain_free");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rob.md
Name: rob

Overview:
- In-order reorder buffer directly downstream of the completion queue.
- Allocates entries at dispatch and consumes the complete packets that the completion queue broadcasts.
- Marks entries done and retires up to R_WIDTH oldest done entries per cycle in program order.
- Retired old physical tags go to the free list; retired destination tags go to the architectural map.

Parameters:
SIZE, 32, number of entries; must be a power of 2
D_WIDTH, 3, dispatch lanes per cycle
C_WIDTH, 3, complete lanes per cycle; matches the completion queue output width
R_WIDTH, 3, retire lanes per cycle
IDX_W, $clog2(SIZE), ROB index width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
dispatch_valid  in  D_WIDTH  per-lane dispatch request
dispatch_arch  in  D_WIDTH x 5  architectural destination register
dispatch_dest  in  D_WIDTH x phy_reg_idx_t  newly allocated physical tag
dispatch_old  in  D_WIDTH x phy_reg_idx_t  previous mapping of dispatch_arch
dispatch_rob_index  out  D_WIDTH x IDX_W  index assigned to each lane
free_slots  out  $clog2(SIZE+1)  unallocated entries
complete  in  C_WIDTH x complete_packet_t  completion broadcast (tag.valid, tag.index, rob_index)
flush  in  1  discard all entries
retire_valid  out  R_WIDTH  lane retires this cycle
retire_arch  out  R_WIDTH x 5  architectural register of retiring entry
retire_dest  out  R_WIDTH x phy_reg_idx_t  physical tag to commit
retire_old  out  R_WIDTH x phy_reg_idx_t  physical tag to free

Behaviour:
- State:
  - head, tail: IDX_W bits, wrap mod SIZE.
  - count: $clog2(SIZE+1) bits.
  - Per entry: valid, done, arch, dest, old.
- Reset (reset==0, async):
  - head=tail=count=0; all valid/done cleared.
  - free_slots=SIZE; retire_valid=0; retire_* data=0.
  - dispatch_rob_index[i]=i.
- free_slots = SIZE-count, combinational from registers only. It excludes same-cycle retirement.
- dispatch_rob_index[i] = (tail+i) mod SIZE, combinational.
- Dispatch acceptance:
  - Accepted lanes are the contiguous run of set dispatch_valid bits starting at lane 0, capped at free_slots.
  - Lanes after the first 0, or beyond free_slots, are ignored and write nothing.
  - At posedge, each accepted lane i writes entry tail+i with valid=1, done=0, and its arch/dest/old; tail advances by the accepted count.
- Completion:
  - For each lane with complete[j].tag.valid, set done of entry complete[j].rob_index at posedge.
  - A completion that targets an invalid entry is ignored.
  - Duplicate lanes hitting the same index are harmless.
- Retire (combinational from registered state):
  - retire_valid[k]=1 iff entries head..head+k are all valid and done.
  - Retirement stops at the first entry that is not done; it never skips.
  - retire_arch/dest/old[k] reflect entry head+k; they are 0 when retire_valid[k]=0.
  - At posedge, retired entries are cleared and head advances by the retired count.
- Latency:
  - Complete presented in cycle t → done set at end of t → retire_valid earliest in t+1.
  - Dispatch in cycle t → earliest retirement in t+2 (complete in t+1).
- count_next = count + accepted - retired. Dispatch and retirement in the same cycle are both applied.
- Full (count==SIZE): all dispatch ignored. Same-cycle retirement does not allow same-cycle dispatch.
- Empty: retire_valid=0.
- Wrap-around: head and tail wrap mod SIZE; retire and dispatch lanes span the wrap seamlessly.
- Flush (synchronous):
  - At posedge, head=tail=count=0 and all valid/done are cleared.
  - Dispatch and complete in the flush cycle are ignored.
  - retire_valid in the flush cycle is still honoured by consumers; those entries are older than the flush point.
- Reset asserted mid-operation clears everything immediately, regardless of clock.

Test Plan:
- Reset: hold reset=0, release at negedge → free_slots=32, retire_valid=000, dispatch_rob_index={2,1,0}.
- Basic flow:
  - Dispatch 3 lanes (arch 1/2/3, dest 10/11/12, old 20/21/22) → next cycle free_slots=29.
  - Complete rob_index 0,1,2 → the following cycle retire_valid=111, retire_dest={12,11,10}, retire_old={22,21,20}.
  - Next cycle free_slots=32.
- Out-of-order completion: dispatch 3, complete only index 1 and 2 → retire_valid=000. Then complete index 0 → next cycle retire_valid=111.
- Full and wrap:
  - Dispatch until free_slots=0; extra dispatch is ignored and tail is unchanged.
  - Complete and retire 3; dispatch 3 → dispatch_rob_index wraps to {2,1,0}; entries retire in order across the wrap.
- Non-contiguous and partial acceptance:
  - dispatch_valid=101 → only lane 0 allocated; free_slots drops by 1.
  - With free_slots=2 and dispatch_valid=111 → 2 allocated.
- Flush: with 5 entries (2 done at head), assert flush → retire_valid=11 that cycle; next cycle free_slots=32, retire_valid=000; a late complete to old index 3 is ignored.
